seq_checker: RTL and testbench

SEQ_CHECKER -- requirements
Module: seq_checker

---
 rtl/seq_pkg.sv | 7 +
 rtl/seq_history.sv | 33 +++
 rtl/seq_checker.sv | 99 +++++++++
 tb/tb_seq_checker.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared types and default thresholds for the sequence checker
package seq_pkg;
    typedef enum logic {HUNT, LOCKED} state_t;
    typedef logic [31:0] sample_t;
    localparam int DEF_LOCK_THRESH = 4;
    localparam int DEF_LOSS_THRESH = 3;
endpackage

// File: rtl/seq_history.sv
// seq_history: three-deep sample history with fill tracking
module seq_history
    import seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        shift_en,
    input  logic        flush,
    input  logic [31:0] data_i,
    output logic [31:0] h0,
    output logic [31:0] h1,
    output logic [31:0] h2,
    output logic        full
);
    logic [1:0] fill;
    // shift new samples in; flush only forgets how many are valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h0   <= '0;
            h1   <= '0;
            h2   <= '0;
            fill <= '0;
        end else if (flush) begin
            fill <= '0;
        end else if (shift_en) begin
            h2   <= h1;
            h1   <= h0;
            h0   <= sample_t'(data_i);
            fill <= full ? fill : fill + 2'd1;
        end
    end
    assign full = fill == 2'd3;
endmodule

// File: rtl/seq_checker.sv
// seq_checker: locks onto x[n]=x[n-2]+x[n-3] streams and counts errors while locked
module seq_checker
    import seq_pkg::*;
#(
    parameter int LOCK_THRESH = DEF_LOCK_THRESH,
    parameter int LOSS_THRESH = DEF_LOSS_THRESH,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_i,
    input  logic [31:0]          data_i,
    input  logic                 clear_i,
    output logic                 lock_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic [31:0]          good_cnt_o,
    output logic [31:0]          exp_o,
    output logic                 exp_vld_o
);
    localparam int RUN_W  = $clog2(LOCK_THRESH + 1);
    localparam int MISS_W = $clog2(LOSS_THRESH + 1);
    state_t               state_q, state_d;
    logic [RUN_W-1:0]     run_q, run_d;
    logic [MISS_W-1:0]    miss_q, miss_d;
    logic                 err_d;
    logic [ERR_CNT_W-1:0] err_cnt_d;
    logic [31:0]          good_d;
    logic [31:0]          h0, h1, h2;
    logic                 full, match;
    seq_history u_hist (
        .clk      (clk),
        .reset    (reset),
        .shift_en (valid_i & ~clear_i),
        .flush    (clear_i),
        .data_i   (data_i),
        .h0       (h0),
        .h1       (h1),
        .h2       (h2),
        .full     (full)
    );
    assign exp_o     = h1 + h2;
    assign exp_vld_o = full;
    assign lock_o    = state_q == LOCKED;
    assign match     = data_i == exp_o;
    // state and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= HUNT;
            run_q      <= '0;
            miss_q     <= '0;
            err_o      <= 1'b0;
            err_cnt_o  <= '0;
            good_cnt_o <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            miss_q     <= miss_d;
            err_o      <= err_d;
            err_cnt_o  <= err_cnt_d;
            good_cnt_o <= good_d;
        end
    end
    // next state: compare only once history is full; clear wins over a sample
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        miss_d    = miss_q;
        err_d     = err_o;
        err_cnt_d = err_cnt_o;
        good_d    = good_cnt_o;
        if (clear_i) begin
            state_d   = HUNT;
            run_d     = '0;
            miss_d    = '0;
            err_d     = 1'b0;
            err_cnt_d = '0;
            good_d    = '0;
        end else if (valid_i && full) begin
            if (state_q == HUNT) begin
                run_d   = !match ? '0 : (run_q == RUN_W'(LOCK_THRESH - 1)) ? '0 : run_q + 1'b1;
                state_d = (match && run_q == RUN_W'(LOCK_THRESH - 1)) ? LOCKED : HUNT;
            end else if (match) begin
                good_d = good_cnt_o + 32'd1;
                miss_d = '0;
            end else begin
                err_d     = 1'b1;
                err_cnt_d = (&err_cnt_o) ? err_cnt_o : err_cnt_o + 1'b1;
                if (miss_q == MISS_W'(LOSS_THRESH - 1)) begin
                    state_d = HUNT;
                    miss_d  = '0;
                    run_d   = '0;
                end else begin
                    miss_d = miss_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_checker.sv
// tb_seq_checker: directed checks of locking, error counting, clear and saturation
module tb_seq_checker;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_i = 1'b0;
    logic        clear_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        lock_o, err_o, exp_vld_o;
    logic [15:0] err_cnt_o;
    logic [31:0] good_cnt_o, exp_o;
    logic        lock_s, err_s, exp_vld_s;
    logic [3:0]  err_cnt_s;
    logic [31:0] good_cnt_s, exp_s;
    logic [31:0] bh0 = '0, bh1 = '0, bh2 = '0;
    int          n_tests = 0, n_fail = 0;
    int          gexp;
    logic [31:0] e_hold;

    always #5 clk = ~clk;

    seq_checker dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .data_i(data_i), .clear_i(clear_i),
        .lock_o(lock_o), .err_o(err_o), .err_cnt_o(err_cnt_o), .good_cnt_o(good_cnt_o),
        .exp_o(exp_o), .exp_vld_o(exp_vld_o)
    );

    seq_checker #(.LOSS_THRESH(32), .ERR_CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .valid_i(valid_i), .data_i(data_i), .clear_i(clear_i),
        .lock_o(lock_s), .err_o(err_s), .err_cnt_o(err_cnt_s), .good_cnt_o(good_cnt_s),
        .exp_o(exp_s), .exp_vld_o(exp_vld_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] d);
        @(negedge clk);
        valid_i = 1'b1;
        data_i  = d;
        @(posedge clk);
        #1 valid_i = 1'b0;
        bh2 = bh1;
        bh1 = bh0;
        bh0 = d;
    endtask

    task automatic send_list(input int n, input logic [31:0] v [0:8]);
        for (int i = 0; i < n; i++) send(v[i]);
    endtask

    task automatic clear_with_sample(input logic [31:0] d);
        @(negedge clk);
        clear_i = 1'b1;
        valid_i = 1'b1;
        data_i  = d;
        @(posedge clk);
        #1 clear_i = 1'b0;
        valid_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_lock", {31'd0, lock_o}, 0);
        check("rst_err", {31'd0, err_o}, 0);
        check("rst_errcnt", {16'd0, err_cnt_o}, 0);
        check("rst_good", good_cnt_o, 0);
        check("rst_expvld", {31'd0, exp_vld_o}, 0);
        check("rst_exp", exp_o, 0);
        @(negedge clk);
        reset = 1'b0;
        bh0 = '0; bh1 = '0; bh2 = '0;
    endtask

    logic [31:0] seq6 [0:8] = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0};

    initial begin
        do_reset();
        send(0); send(1); send(1);
        check("fill_expvld", {31'd0, exp_vld_o}, 1);
        check("fill_exp", exp_o, 1);
        send(1); send(2); send(2);
        check("prelock", {31'd0, lock_o}, 0);
        send(3);
        check("lock_030", {31'd0, lock_o}, 1);
        check("errcnt_030", {16'd0, err_cnt_o}, 0);
        check("good_030", good_cnt_o, 0);
        check("exp_030", exp_o, 4);
        send(4); send(5); send(7);
        check("good_457", good_cnt_o, 3);
        send(100); send(12); send(16); send(21); send(28);
        check("errcnt_031", {16'd0, err_cnt_o}, 3);
        check("err_031", {31'd0, err_o}, 1);
        check("lock_031", {31'd0, lock_o}, 1);
        check("good_031", good_cnt_o, 5);
        gexp = 5;
        for (int i = 1; i <= 5; i++) begin
            send(bh1 + bh2);
            gexp++;
            e_hold = bh1 + bh2;
            for (int j = 0; j < i; j++) begin
                @(posedge clk);
                #1;
                check("gap_good", good_cnt_o, gexp);
                check("gap_exp", exp_o, e_hold);
                check("gap_lock", {31'd0, lock_o}, 1);
            end
        end
        check("gap_errcnt", {16'd0, err_cnt_o}, 3);

        do_reset();
        send_list(6, seq6);
        send(3); send(4); send(5);
        check("lock_h345", {31'd0, lock_o}, 1);
        send(0); send(0);
        check("loss_2", {31'd0, lock_o}, 1);
        send(0);
        check("loss_3", {31'd0, lock_o}, 0);
        check("loss_errcnt", {16'd0, err_cnt_o}, 3);
        send(0); send(0); send(0);
        check("relock_3", {31'd0, lock_o}, 0);
        send(0);
        check("relock_4", {31'd0, lock_o}, 1);
        check("relock_errcnt", {16'd0, err_cnt_o}, 3);

        do_reset();
        send_list(6, seq6);
        send(3); send(9); send(7);
        check("pre_clr_errcnt", {16'd0, err_cnt_o}, 2);
        check("pre_clr_lock", {31'd0, lock_o}, 1);
        clear_with_sample(5);
        check("clr_lock", {31'd0, lock_o}, 0);
        check("clr_err", {31'd0, err_o}, 0);
        check("clr_errcnt", {16'd0, err_cnt_o}, 0);
        check("clr_good", good_cnt_o, 0);
        check("clr_expvld", {31'd0, exp_vld_o}, 0);
        send_list(6, seq6);
        check("clr_6", {31'd0, lock_o}, 0);
        send(3);
        check("clr_relock", {31'd0, lock_o}, 1);

        clear_with_sample(0);
        send(32'hFFFF_FFFF); send(1); send(1);
        check("wrap_exp", exp_o, 0);
        send(0); send(2); send(1);
        check("wrap_prelock", {31'd0, lock_o}, 0);
        send(2);
        check("wrap_lock", {31'd0, lock_o}, 1);
        check("wrap_errcnt", {16'd0, err_cnt_o}, 0);
        check("sat_lock0", {31'd0, lock_s}, 1);
        for (int i = 0; i < 20; i++) send(bh1 + bh2 + 32'd1);
        check("sat_errcnt", {28'd0, err_cnt_s}, 15);
        check("sat_lock", {31'd0, lock_s}, 1);
        check("sat_err", {31'd0, err_s}, 1);
        check("dflt_errcnt", {16'd0, err_cnt_o}, 3);
        check("dflt_lock", {31'd0, lock_o}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
